// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM port shared by instruction fetch and the load/store buffer.
// Define MEM_ARB_IO_STALL_EN to stall stores into the IO window while io_buffer_full is high.
module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              load_store_sgn,
    input  logic [5:0]        load_store_op,
    input  logic [ADDR_W-1:0] load_store_addr,
    input  logic [31:0]       store_data,
    output logic              mem_valid,
    output logic [31:0]       mem_res,
    output logic              finish_store,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);
    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        nxt;
    logic [2:0]        len_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [5:0]        op_q;
    logic [23:0]       data_q;
    logic [23:0]       buf_q;
    logic [31:0]       word_now;
    logic              lsb_pend;
    logic              if_pend;
    logic              take_lsb;
    logic              take_if;
    logic              done_edge;
    logic              stall_new;
    logic              stall_cur;

    function automatic logic [2:0] op_len(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [31:0] assemble(input logic [23:0] low, input logic [7:0] b,
                                             input logic [1:0] idx);
        case (idx)
            2'd0:    return {24'd0, b};
            2'd1:    return {16'd0, b, low[7:0]};
            2'd2:    return {8'd0, b, low[15:0]};
            default: return {b, low};
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] raw);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] w;
        sb = raw[7:0];
        sh = raw[15:0];
        case (op)
            OP_LB:   w = sb;
            OP_LH:   w = sh;
            OP_LBU:  w = {24'd0, raw[7:0]};
            OP_LHU:  w = {16'd0, raw[15:0]};
            default: w = raw;
        endcase
        return w;
    endfunction

    // Upper store bytes only; byte 0 goes straight from store_data on accept.
    function automatic logic [7:0] pick_byte(input logic [23:0] d, input logic [1:0] idx);
        case (idx)
            2'd1:    return d[7:0];
            2'd2:    return d[15:8];
            default: return d[23:16];
        endcase
    endfunction

`ifdef MEM_ARB_IO_STALL_EN
    assign stall_new = (load_store_addr[17:16] == IO_HI) && io_buffer_full;
    assign stall_cur = (addr_q[17:16] == IO_HI) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign stall_new = 1'b0;
    assign stall_cur = 1'b0;
`endif

    assign nxt       = cnt + 3'd1;
    assign len_q     = op_len(op_q);
    assign done_edge = (nxt == len_q);
    assign word_now  = assemble(buf_q, mem_din, cnt[1:0]);
    assign mem_wr    = wr_q & rdy;

    // A requester still showing its completion pulse is masked so it is not served twice.
    assign lsb_pend = load_store_sgn && !mem_valid && !finish_store;
    assign if_pend  = if_req && !if_done;
    assign take_lsb = rdy && (state == IDLE) && !rollback && lsb_pend;
    assign take_if  = rdy && (state == IDLE) && !rollback && !lsb_pend && if_pend;

    always_ff @(posedge clk) begin
        if (take_lsb) begin
            addr_q <= load_store_addr;
            op_q   <= load_store_op;
            data_q <= store_data[31:8];
        end else if (take_if) begin
            addr_q <= if_addr;
            op_q   <= OP_LW;
        end
        if (rdy && (state == IFETCH || state == LOAD)) begin
            case (cnt[1:0])
                2'd0:    buf_q[7:0]   <= mem_din;
                2'd1:    buf_q[15:8]  <= mem_din;
                2'd2:    buf_q[23:16] <= mem_din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wr_q         <= 1'b0;
            mem_a        <= '0;
            mem_dout     <= '0;
            if_done      <= 1'b0;
            if_data      <= '0;
            mem_valid    <= 1'b0;
            mem_res      <= '0;
            finish_store <= 1'b0;
        end else if (rdy) begin
            if_done      <= 1'b0;
            mem_valid    <= 1'b0;
            finish_store <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_lsb) begin
                        mem_a <= load_store_addr;
                        cnt   <= '0;
                        if (is_store(load_store_op)) begin
                            state    <= STORE;
                            mem_dout <= store_data[7:0];
                            wr_q     <= !stall_new;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (take_if) begin
                        state <= IFETCH;
                        mem_a <= if_addr;
                        cnt   <= '0;
                    end
                end
                IFETCH, LOAD: begin
                    if (rollback) begin
                        state <= IDLE;
                        mem_a <= '0;
                        cnt   <= '0;
                    end else if (done_edge) begin
                        state <= IDLE;
                        mem_a <= '0;
                        cnt   <= '0;
                        if (state == IFETCH) begin
                            if_done <= 1'b1;
                            if_data <= word_now;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_res   <= extend(op_q, word_now);
                        end
                    end else begin
                        cnt   <= nxt;
                        mem_a <= addr_q + ADDR_W'(nxt);
                    end
                end
                STORE: begin
                    // wr_q low means byte cnt is still pending (IO stall); rollback cannot cancel a store.
                    if (!wr_q) begin
                        wr_q <= !stall_cur;
                    end else if (done_edge) begin
                        state        <= IDLE;
                        wr_q         <= 1'b0;
                        mem_a        <= '0;
                        mem_dout     <= '0;
                        cnt          <= '0;
                        finish_store <= 1'b1;
                    end else begin
                        cnt      <= nxt;
                        mem_a    <= addr_q + ADDR_W'(nxt);
                        mem_dout <= pick_byte(data_q, nxt[1:0]);
                        wr_q     <= !stall_cur;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench for mem_arbiter against a byte-array memory model.
module tb_mem_arbiter;
    localparam logic [5:0] LB = 6'd1, LH = 6'd2, LW = 6'd3, LBU = 6'd4, LHU = 6'd5;
    localparam logic [5:0] SB = 6'd6, SH = 6'd7, SW = 6'd8;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, if_req, if_done, load_store_sgn, mem_valid, finish_store;
    logic        mem_wr, io_buffer_full;
    logic [31:0] if_addr, if_data, load_store_addr, store_data, mem_res, mem_a;
    logic [5:0]  load_store_op;
    logic [7:0]  mem_din, mem_dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];
    int          wlog_c[$];

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .load_store_sgn(load_store_sgn), .load_store_op(load_store_op),
        .load_store_addr(load_store_addr), .store_data(store_data),
        .mem_valid(mem_valid), .mem_res(mem_res), .finish_store(finish_store),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[15:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
            wlog_a.push_back(mem_a);
            wlog_d.push_back(mem_dout);
            wlog_c.push_back(cyc);
        end
    end

    function automatic int n_of(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
        longint      v;
        logic [31:0] ai;
        v = 0;
        for (int i = 0; i < n_of(op); i++) begin
            ai = a + 32'(i);
            v  = v + longint'(ref_mem[ai[15:0]]) * (longint'(1) << (8 * i));
        end
        if (op == LB && v >= 128) v = v - 256;
        if (op == LH && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    function automatic void model_store(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] d);
        logic [31:0] ai;
        for (int i = 0; i < n_of(op); i++) begin
            ai = a + 32'(i);
            ref_mem[ai[15:0]] = 8'((d >> (8 * i)) & 32'hFF);
        end
    endfunction

    // True when the write log holds exactly the expected bytes of one store, in order.
    function automatic bit log_matches(input logic [5:0] op, input logic [31:0] a,
                                       input logic [31:0] d);
        if (wlog_a.size() != n_of(op)) return 1'b0;
        for (int i = 0; i < n_of(op); i++) begin
            if (wlog_a[i] !== a + 32'(i)) return 1'b0;
            if (wlog_d[i] !== 8'((d >> (8 * i)) & 32'hFF)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void clear_log();
        wlog_a.delete();
        wlog_d.delete();
        wlog_c.delete();
    endfunction

    task automatic lsb_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                           input bit jitter, output logic [31:0] res, output int lat,
                           output logic [31:0] after_a);
        load_store_sgn  = 1'b1;
        load_store_op   = op;
        load_store_addr = a;
        store_data      = d;
        lat = -1;
        res = '0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (jitter) rdy = ($urandom_range(0, 3) != 0);
            if (mem_valid || finish_store) begin
                lat = i;
                res = mem_res;
                break;
            end
        end
        rdy = 1'b1;
        @(negedge clk);
        after_a = mem_a;
        load_store_sgn = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] a, input bit jitter, output logic [31:0] res,
                          output int lat, output logic [31:0] after_a);
        if_req  = 1'b1;
        if_addr = a;
        lat = -1;
        res = '0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (jitter) rdy = ($urandom_range(0, 3) != 0);
            if (if_done) begin
                lat = i;
                res = if_data;
                break;
            end
        end
        rdy = 1'b1;
        @(negedge clk);
        after_a = mem_a;
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; if_req = 1'b0; if_addr = '0;
        load_store_sgn = 1'b0; load_store_op = '0; load_store_addr = '0; store_data = '0;
        io_buffer_full = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({if_done, if_data, mem_valid, mem_res, finish_store, mem_dout, mem_a, mem_wr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got mem_a=%h mem_wr=%b if_data=%h mem_res=%h want all 0",
                     mem_a, mem_wr, if_data, mem_res);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ifetch();
        logic [31:0] res, aa;
        int lat;
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
        for (int i = 0; i < 4; i++) ref_mem[i] = ram[i];
        if_txn(32'h0, 1'b0, res, lat, aa);
        checks++;
        if (res !== 32'h00000513) begin errors++; $display("FAIL if_data got %h want 00000513", res); end
        checks++;
        if (lat != 5) begin errors++; $display("FAIL if_latency got %0d want 5", lat); end
        checks++;
        if (aa !== 32'h0) begin errors++; $display("FAIL if_no_reissue got mem_a=%h want 0", aa); end
    endtask

    task automatic test_loads();
        logic [31:0] res, aa;
        int lat;
        logic [5:0]  ops [4]  = '{LB, LBU, LH, LHU};
        logic [31:0] adr [4]  = '{32'h100, 32'h100, 32'h200, 32'h200};
        logic [31:0] want [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF9001, 32'h00009001};
        int          wlat [4] = '{2, 2, 3, 3};
        ram[16'h100] = 8'h80; ram[16'h200] = 8'h01; ram[16'h201] = 8'h90;
        ref_mem[16'h100] = 8'h80; ref_mem[16'h200] = 8'h01; ref_mem[16'h201] = 8'h90;
        for (int k = 0; k < 4; k++) begin
            lsb_txn(ops[k], adr[k], 32'h0, 1'b0, res, lat, aa);
            checks++;
            if (res !== want[k]) begin errors++; $display("FAIL load_ext op%0d got %h want %h", ops[k], res, want[k]); end
            checks++;
            if (lat != wlat[k]) begin errors++; $display("FAIL load_latency op%0d got %0d want %0d", ops[k], lat, wlat[k]); end
            checks++;
            if (aa !== 32'h0) begin errors++; $display("FAIL load_no_reissue got mem_a=%h want 0", aa); end
        end
    endtask

    task automatic test_store();
        logic [31:0] res, aa;
        int lat;
        bit consec;
        clear_log();
        lsb_txn(SW, 32'h1000, 32'h11223344, 1'b0, res, lat, aa);
        model_store(SW, 32'h1000, 32'h11223344);
        checks++;
        if (!log_matches(SW, 32'h1000, 32'h11223344)) begin
            errors++;
            $display("FAIL sw_bytes got %0d writes first=(%h,%h) want 4 writes (1000,44)..(1003,11)",
                     wlog_a.size(), (wlog_a.size() > 0) ? wlog_a[0] : 32'hx, (wlog_d.size() > 0) ? wlog_d[0] : 8'hx);
        end
        consec = (wlog_c.size() == 4);
        for (int i = 1; i < wlog_c.size(); i++) if (wlog_c[i] != wlog_c[0] + i) consec = 1'b0;
        checks++;
        if (!consec) begin errors++; $display("FAIL sw_consecutive got %0d writes non-consecutive want 4 consecutive", wlog_c.size()); end
        checks++;
        if (lat != 5) begin errors++; $display("FAIL sw_finish_latency got %0d want 5", lat); end
        checks++;
        if (aa !== 32'h0) begin errors++; $display("FAIL sw_no_reissue got mem_a=%h want 0", aa); end
        lsb_txn(LW, 32'h1000, 32'h0, 1'b0, res, lat, aa);
        checks++;
        if (res !== 32'h11223344) begin errors++; $display("FAIL sw_readback got %h want 11223344", res); end
        clear_log();
        lsb_txn(SH, 32'h1010, 32'hCAFEBEEF, 1'b0, res, lat, aa);
        model_store(SH, 32'h1010, 32'hCAFEBEEF);
        checks++;
        if (!log_matches(SH, 32'h1010, 32'hCAFEBEEF) || lat != 3) begin
            errors++; $display("FAIL sh_bytes got %0d writes lat %0d want 2 writes lat 3", wlog_a.size(), lat);
        end
    endtask

    task automatic test_priority();
        logic [31:0] exp_if;
        int seen, got, extra;
        for (int i = 0; i < 4; i++) begin
            ram[16'h40 + i] = 8'($urandom); ref_mem[16'h40 + i] = ram[16'h40 + i];
            ram[16'h300 + i] = 8'($urandom); ref_mem[16'h300 + i] = ram[16'h300 + i];
        end
        exp_if = model_load(LW, 32'h40);
        if_req = 1'b1; if_addr = 32'h40;
        load_store_sgn = 1'b1; load_store_op = LW; load_store_addr = 32'h300;
        seen = -1; got = -1; extra = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if_done) extra++;
            if (mem_valid) begin seen = i; break; end
        end
        checks++;
        if (seen != 5 || mem_res !== model_load(LW, 32'h300)) begin
            errors++; $display("FAIL prio_lsb_first got lat %0d res %h want lat 5 res %h", seen, mem_res, model_load(LW, 32'h300));
        end
        @(negedge clk);
        load_store_sgn = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_valid) extra++;
            if (if_done) begin got = k; break; end
        end
        checks++;
        if (got != 4) begin errors++; $display("FAIL prio_if_after got %0d want 4", got); end
        checks++;
        if (if_data !== exp_if) begin errors++; $display("FAIL prio_if_data got %h want %h", if_data, exp_if); end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL prio_duplicate got %0d extra pulses want 0", extra); end
        @(negedge clk);
        if_req = 1'b0;
    endtask

    task automatic test_rollback();
        int nv, fs;
        logic [31:0] r;
        // Abort a word load at its third edge.
        load_store_sgn = 1'b1; load_store_op = LW; load_store_addr = 32'h400;
        repeat (2) @(negedge clk);
        rollback = 1'b1; load_store_sgn = 1'b0;
        @(negedge clk);
        rollback = 1'b0;
        checks++;
        if (mem_a !== 32'h0 || mem_valid !== 1'b0) begin
            errors++; $display("FAIL rb_lw_idle got mem_a=%h valid=%b want 0 0", mem_a, mem_valid);
        end
        nv = 0;
        repeat (6) begin @(negedge clk); if (mem_valid) nv++; end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL rb_lw_no_valid got %0d pulses want 0", nv); end
        // A rollback during a store must not cancel it.
        clear_log();
        load_store_sgn = 1'b1; load_store_op = SH; load_store_addr = 32'h500; store_data = 32'h0000BEEF;
        @(negedge clk);
        rollback = 1'b1;
        fs = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (finish_store) begin fs++; break; end
        end
        @(negedge clk);
        load_store_sgn = 1'b0; rollback = 1'b0;
        model_store(SH, 32'h500, 32'h0000BEEF);
        checks++;
        if (fs != 1 || !log_matches(SH, 32'h500, 32'h0000BEEF)) begin
            errors++; $display("FAIL rb_sh_completes got finish=%0d writes=%0d want 1 2", fs, wlog_a.size());
        end
        // Rollback while idle suppresses the accept on that edge only.
        rollback = 1'b1; load_store_sgn = 1'b1; load_store_op = LB; load_store_addr = 32'h100;
        @(negedge clk);
        checks++;
        if (mem_a !== 32'h0) begin errors++; $display("FAIL rb_idle_suppress got mem_a=%h want 0", mem_a); end
        rollback = 1'b0;
        nv = -1; r = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mem_valid) begin nv = i; r = mem_res; break; end
        end
        @(negedge clk);
        load_store_sgn = 1'b0;
        checks++;
        if (nv != 2 || r !== 32'hFFFFFF80) begin
            errors++; $display("FAIL rb_idle_then_lb got lat %0d res %h want 2 FFFFFF80", nv, r);
        end
    endtask

    task automatic test_rdy_pause();
        int bad, fs;
        logic [31:0] d;
        d = $urandom;
        clear_log();
        load_store_sgn = 1'b1; load_store_op = SW; load_store_addr = 32'h1100; store_data = d;
        @(negedge clk);
        rdy = 1'b0;
        bad = 0;
        repeat (3) begin @(negedge clk); if (mem_wr !== 1'b0) bad++; end
        checks++;
        if (bad != 0 || wlog_a.size() != 0) begin
            errors++; $display("FAIL rdy_hold_wr got %0d wr-high cycles %0d writes want 0 0", bad, wlog_a.size());
        end
        rdy = 1'b1;
        fs = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (finish_store) begin fs = i; break; end
        end
        @(negedge clk);
        load_store_sgn = 1'b0;
        model_store(SW, 32'h1100, d);
        checks++;
        if (fs != 4 || !log_matches(SW, 32'h1100, d)) begin
            errors++; $display("FAIL rdy_resume got finish at %0d writes %0d want 4 4", fs, wlog_a.size());
        end
    endtask

    task automatic test_io();
        int bad;
        clear_log();
        io_buffer_full = 1'b1;
        load_store_sgn = 1'b1; load_store_op = SB; load_store_addr = 32'h30000; store_data = 32'h5A;
`ifdef MEM_ARB_IO_STALL_EN
        bad = 0;
        repeat (3) begin @(negedge clk); if (mem_wr !== 1'b0) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL io_stall got %0d write cycles want 0", bad); end
        io_buffer_full = 1'b0;
        @(negedge clk);
`else
        bad = 0;
        @(negedge clk);
`endif
        checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h5A) begin
            errors++; $display("FAIL io_write got wr=%b a=%h d=%h want 1 30000 5a", mem_wr, mem_a, mem_dout);
        end
        @(negedge clk);
        checks++;
        if (finish_store !== 1'b1) begin errors++; $display("FAIL io_finish got %b want 1", finish_store); end
        @(negedge clk);
        load_store_sgn = 1'b0; io_buffer_full = 1'b0;
        model_store(SB, 32'h30000, 32'h5A);
        checks++;
        if (wlog_a.size() != 1) begin errors++; $display("FAIL io_single_write got %0d want 1", wlog_a.size()); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, res, exp, aa;
        logic [5:0]  op;
        int lat, kind;
        logic [5:0] lops [5] = '{LB, LH, LW, LBU, LHU};
        logic [5:0] sops [3] = '{SB, SH, SW};
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 8);
            a = 32'h2000 + $urandom_range(0, 32'h5FF0);
            d = $urandom;
            if (kind < 5) begin
                op = lops[kind];
                exp = model_load(op, a);
                lsb_txn(op, a, d, 1'b1, res, lat, aa);
                checks++;
                if (lat < 0 || res !== exp) begin
                    errors++; $display("FAIL rand_load op%0d @%h got %h lat %0d want %h", op, a, res, lat, exp);
                end
            end else if (kind < 8) begin
                op = sops[kind - 5];
                clear_log();
                lsb_txn(op, a, d, 1'b1, res, lat, aa);
                model_store(op, a, d);
                checks++;
                if (lat < 0 || !log_matches(op, a, d)) begin
                    errors++; $display("FAIL rand_store op%0d @%h d %h got %0d writes lat %0d", op, a, d, wlog_a.size(), lat);
                end
            end else begin
                exp = model_load(LW, a);
                if_txn(a, 1'b1, res, lat, aa);
                checks++;
                if (lat < 0 || res !== exp) begin
                    errors++; $display("FAIL rand_if @%h got %h lat %0d want %h", a, res, lat, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] res, aa;
        int lat;
        load_store_sgn = 1'b1; load_store_op = SW; load_store_addr = 32'h9000; store_data = 32'hA5A5A5A5;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({if_done, if_data, mem_valid, mem_res, finish_store, mem_dout, mem_a, mem_wr} !== '0) begin
            errors++; $display("FAIL reset_mid_store got wr=%b a=%h d=%h want all 0", mem_wr, mem_a, mem_dout);
        end
        load_store_sgn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        lsb_txn(LBU, 32'h100, 32'h0, 1'b0, res, lat, aa);
        checks++;
        if (res !== 32'h00000080 || lat != 2) begin
            errors++; $display("FAIL reset_recover got %h lat %0d want 00000080 lat 2", res, lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        test_reset();
        test_ifetch();
        test_loads();
        test_store();
        test_priority();
        test_rollback();
        test_rdy_pause();
        test_io();
        test_random();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
